// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin channel arbiter.
//   arb_state_e : two-state arbiter FSM encoding (IDLE / GRANTED).
//   idx_w()     : index width helper, $clog2(n) with a floor of 1 bit so
//                 that small parameter values still give a legal vector.
package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Scans requesters ptr_i+1, ptr_i+2, ... wrapping modulo N and ending at
// ptr_i itself; reports the first set request.
// Ports:
//   req_i   [N]      request vector
//   ptr_i   [IDX_W]  last-served index (search starts just after it)
//   found_o          any request set
//   idx_o   [IDX_W]  index of the winning requester (0 when none)
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= N; off++) begin
      // Explicit wrap so non-power-of-two N never indexes past N-1.
      cand = int'(ptr_i) + off;
      if (cand > N - 1) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/rr_channel_arbiter.sv
// Round-robin arbiter sharing one W-bit pass-through channel among N
// requesters, with a bounded hold time per owner.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req   [N]       level-sensitive requests
//   i     [N*W]     requester data, requester k at [k*W +: W]
//   grant [N]       registered one-hot (or zero) grant
//   o     [W]       shared channel output, zero-latency mux over grant
//   o_valid         |grant
//   owner [IDX_W]   current owner index, 0 when idle
module rr_channel_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req,
  input  logic [N*W-1:0]      i,
  output logic [N-1:0]        grant,
  output logic [W-1:0]        o,
  output logic                o_valid,
  output logic [idx_w(N)-1:0] owner
);

  localparam int IDX_W  = idx_w(N);
  localparam int HOLD_W = idx_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(N - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]  owner_q, owner_d;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [N-1:0]      pick_onehot;
  logic [W-1:0]      o_mux;

  // While GRANTED, ptr_q always equals owner_q, so one picker driven by
  // ptr_q serves IDLE arbitration, release and timeout re-arbitration.
  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    owner_d = owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANTED;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          hold_d  = '0;
        end
      end
      ST_GRANTED: begin
        if (!req[owner_q]) begin
          // Release: hand off directly, or fall back to idle.
          if (pick_found) begin
            grant_d = pick_onehot;
            owner_d = pick_idx;
            ptr_d   = pick_idx;
            hold_d  = '0;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            owner_d = '0;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_LAST) begin
          // Timeout: owner is last in search order and still requesting,
          // so the picker always hits; it re-grants the owner only when
          // nobody else is waiting.
          grant_d = pick_onehot;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        owner_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      hold_q  <= '0;
      grant_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
    end
  end

  // One-hot AND-OR mux; a zero grant yields zero on the channel.
  always_comb begin
    o_mux = '0;
    for (int k = 0; k < N; k++) begin
      o_mux = o_mux | ({W{grant_q[k]}} & i[k*W +: W]);
    end
  end

  assign o       = o_mux;
  assign o_valid = |grant_q;
  assign grant   = grant_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_rr_channel_arbiter.sv
module tb_rr_channel_arbiter;

  localparam int W = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     req;
  logic [4*W-1:0] din;

  logic [3:0]   grant_a, grant_b;
  logic [2:0]   grant_c;
  logic [W-1:0] o_a, o_b, o_c;
  logic         o_valid_a, o_valid_b, o_valid_c;
  logic [1:0]   owner_a, owner_b, owner_c;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // A: N=4 MAX_HOLD=2, B: N=4 MAX_HOLD=8, C: N=3 MAX_HOLD=1
  rr_channel_arbiter #(.N(4), .W(W), .MAX_HOLD(2)) dut_a (
    .clk(clk), .reset(reset), .req(req), .i(din),
    .grant(grant_a), .o(o_a), .o_valid(o_valid_a), .owner(owner_a));

  rr_channel_arbiter #(.N(4), .W(W), .MAX_HOLD(8)) dut_b (
    .clk(clk), .reset(reset), .req(req), .i(din),
    .grant(grant_b), .o(o_b), .o_valid(o_valid_b), .owner(owner_b));

  rr_channel_arbiter #(.N(3), .W(W), .MAX_HOLD(1)) dut_c (
    .clk(clk), .reset(reset), .req(req[2:0]), .i(din[3*W-1:0]),
    .grant(grant_c), .o(o_c), .o_valid(o_valid_c), .owner(owner_c));

  // Reference model: owner = -1 when idle, held = cycles granted so far.
  int m_owner[3];
  int m_ptr[3];
  int m_held[3];

  function automatic int nn(input int m);
    return (m == 2) ? 3 : 4;
  endfunction

  function automatic int mh(input int m);
    if (m == 0) return 2;
    if (m == 1) return 8;
    return 1;
  endfunction

  function automatic int choose(input int n, input int p, input logic [3:0] r);
    for (int off = 1; off <= n; off++) begin
      int c;
      c = (p + off) % n;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    for (int m = 0; m < 3; m++) begin
      logic [3:0] r;
      int k;
      r = req & ((m == 2) ? 4'b0111 : 4'b1111);
      if (reset) begin
        m_owner[m] = -1;
        m_ptr[m]   = nn(m) - 1;
        m_held[m]  = 0;
      end else if (m_owner[m] < 0 || !r[m_owner[m]] || m_held[m] == mh(m)) begin
        k = choose(nn(m), m_ptr[m], r);
        if (k >= 0) begin
          m_owner[m] = k;
          m_ptr[m]   = k;
          m_held[m]  = 1;
        end else begin
          m_owner[m] = -1;
          m_held[m]  = 0;
        end
      end else begin
        m_held[m] = m_held[m] + 1;
      end
    end
  endtask

  function automatic logic [31:0] exp_grant(input int m);
    return (m_owner[m] < 0) ? 32'd0 : (32'd1 << m_owner[m]);
  endfunction

  function automatic logic [31:0] exp_owner(input int m);
    return (m_owner[m] < 0) ? 32'd0 : 32'(m_owner[m]);
  endfunction

  function automatic logic [31:0] exp_o(input int m);
    return (m_owner[m] < 0) ? 32'd0 : 32'(din[m_owner[m]*W +: W]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic check_all();
    check("a_grant",   32'(grant_a),   exp_grant(0));
    check("a_owner",   32'(owner_a),   exp_owner(0));
    check("a_o_valid", 32'(o_valid_a), 32'(m_owner[0] >= 0));
    check("a_o",       32'(o_a),       exp_o(0));
    check("b_grant",   32'(grant_b),   exp_grant(1));
    check("b_owner",   32'(owner_b),   exp_owner(1));
    check("b_o_valid", 32'(o_valid_b), 32'(m_owner[1] >= 0));
    check("b_o",       32'(o_b),       exp_o(1));
    check("c_grant",   32'(grant_c),   exp_grant(2));
    check("c_owner",   32'(owner_c),   exp_owner(2));
    check("c_o_valid", 32'(o_valid_c), 32'(m_owner[2] >= 0));
    check("c_o",       32'(o_c),       exp_o(2));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] ga;
    logic [3:0] gb;
    logic [2:0] gc;
  } vec_t;

  vec_t tbl[16];

  initial begin
    reset = 1'b1;
    req   = '0;
    din   = '0;
    for (int m = 0; m < 3; m++) begin
      m_owner[m] = -1;
      m_ptr[m]   = nn(m) - 1;
      m_held[m]  = 0;
    end

    // reset 2 cycles, rotation under full load, release handoff, idle
    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 3'b000};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 3'b000};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001, 3'b001};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001, 3'b010};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0010, 4'b0001, 3'b100};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0010, 4'b0001, 3'b001};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0100, 4'b0001, 3'b010};
    tbl[7]  = '{1'b0, 4'b1111, 4'b0100, 4'b0001, 3'b100};
    tbl[8]  = '{1'b0, 4'b1111, 4'b1000, 4'b0001, 3'b001};
    tbl[9]  = '{1'b0, 4'b1111, 4'b1000, 4'b0001, 3'b010};
    tbl[10] = '{1'b0, 4'b1111, 4'b0001, 4'b0010, 3'b100};
    tbl[11] = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 3'b010};
    tbl[12] = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 3'b010};
    tbl[13] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 3'b000};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 3'b000};
    tbl[15] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 3'b000};

    for (int r = 0; r < 16; r++) begin
      reset = tbl[r].rst;
      req   = tbl[r].req;
      din   = 8'($urandom);
      tick();
      check("tbl_a_grant",   32'(grant_a),   32'(tbl[r].ga));
      check("tbl_b_grant",   32'(grant_b),   32'(tbl[r].gb));
      check("tbl_c_grant",   32'(grant_c),   32'(tbl[r].gc));
      check("tbl_a_o_valid", 32'(o_valid_a), 32'(|tbl[r].ga));
    end

    // Pass-through: requester 2 alone, data follows with zero latency
    reset = 1'b0;
    req   = 4'b0100;
    din   = 8'hFF;
    din[2*W +: W] = 2'b01;
    tick();
    check("pt_grant", 32'(grant_a), 32'h4);
    for (int k = 0; k < 3; k++) begin
      logic [W-1:0] v;
      v = (k == 1) ? 2'b00 : 2'b01;
      din[2*W +: W] = v;
      #1;
      check("pt_o_same_cycle", 32'(o_a), 32'(v));
      tick();
    end

    // Timeout with a single requester: B stays granted across its wrap
    req = 4'b1000;
    tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      check("single_b_grant", 32'(grant_b), 32'h8);
      check("single_a_grant", 32'(grant_a), 32'h8);
    end

    // Reset mid-grant
    req = 4'b0100;
    tick();
    tick();
    check("mid_pre_grant", 32'(grant_b), 32'h4);
    reset = 1'b1;
    tick();
    check("mid_rst_grant", 32'(grant_b), 32'h0);
    check("mid_rst_owner", 32'(owner_b), 32'h0);
    check("mid_rst_o",     32'(o_b),     32'h0);
    reset = 1'b0;
    tick();
    check("mid_post_grant", 32'(grant_b), 32'h4);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) != 0) begin
        req = 4'($urandom);
      end
      din = 8'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
